absorb_controller: RTL and testbench
====================================

ABSORB_CONTROLLER -- requirements
Module: absorb_controller

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous active-low reset; 0 resets immediately.
REQ-003 SHALL have start, input, 1: request a new message; accepted only in IDLE.
REQ-004 SHALL have msg_len, input, LEN_W: message length in bytes; sampled when start is accepted.
REQ-005 SHALL have mode, input, 1: 0 = SHAKE128 (21 words/block), 1 = SHAKE256 (17 words/block); sampled when start is accepted.
REQ-006 SHALL have din, input, w; din_valid, input, 1; din_ready, output, 1: message word stream, valid/ready handshake.
REQ-007 SHALL have pad_data_in, output, w: word presented to the padding generator; din when a word is consumed, else 0.
REQ-008 SHALL have pad_remaining_valid_bytes, output, w_byte_width; pad_enable, output, 1; pad_last_word_in_block, output, 1; pad_reset, output, 1: padding-generator controls.
REQ-009 SHALL have absorb_valid, output, 1; absorb_idx, output, 5: strobe and lane index of the word XORed into the state this cycle.
REQ-010 SHALL have perm_start, output, 1; perm_done, input, 1: permutation handshake.
REQ-011 SHALL have busy, output, 1; done, output, 1: busy high outside IDLE; done is a one-cycle pulse at message end.

Function
REQ-012 SHALL implement FSM states IDLE, ABSORB, PAD, PERMUTE.
REQ-013 IDLE: start=1 -> latch msg_len into rem, latch rate, pulse pad_reset, clear absorb_idx and pad_started; go to ABSORB when msg_len>0, else to PAD.
REQ-014 ABSORB: din_ready=1; each handshake emits absorb_valid in the same cycle, increments absorb_idx, and reduces rem by min(rem,8).
REQ-015 rem>=8: pad_enable=0. rem in 1..7: pad_enable=1, pad_remaining_valid_bytes=rem, and pad_started is set.
REQ-016 Once rem reaches 0 and the block is not full, the FSM SHALL enter PAD.
REQ-017 PAD: din_ready=0, pad_data_in=0, pad_enable=1, pad_remaining_valid_bytes=0, absorb_valid=1 every cycle; pad_started is set.
REQ-018 pad_last_word_in_block SHALL be 1 exactly when absorb_valid=1 and absorb_idx=rate-1; the word after that SHALL go to PERMUTE.
REQ-019 PERMUTE: pulse perm_start for one cycle on entry, then hold until perm_done=1 with absorb_idx cleared.
REQ-020 On perm_done with pad_started=1: pulse done and return to IDLE. With pad_started=0: go to ABSORB when rem>0, else to PAD.
REQ-021 din_valid=0 in ABSORB SHALL stall without changing state, rem or absorb_idx.
REQ-022 start while busy SHALL be ignored; perm_done outside PERMUTE SHALL be ignored.
REQ-023 Message ending exactly on a block boundary SHALL produce one extra all-pad block.

Reset
REQ-024 rst=0 SHALL force IDLE, rem=0, absorb_idx=0, pad_started=0, and every output to 0, including mid-block or mid-permutation.
REQ-025 The first cycle after reset release SHALL accept start.

Configuration
REQ-026 With ABSORB_CTRL_SHAKE256_EN defined, mode selects the rate per REQ-005.
REQ-027 Without ABSORB_CTRL_SHAKE256_EN, the rate SHALL be fixed at 21 words, mode is ignored, and the 17-word compare logic is absent.

Structure
REQ-028 w, w_byte_width, w_byte_size, LEN_W=32, RATE128_WORDS=21, RATE256_WORDS=17 and the FSM state enum SHALL live in keccak_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the padding generator is instantiated by the parent.

Verification
REQ-030 Empty message, mode 0 -> 21 absorb_valid cycles in PAD, idx0 pad_enable=1 with remaining 0, idx20 last_word=1, one perm_start, done after perm_done.
REQ-031 msg_len=7, mode 0 -> one din handshake with pad_remaining_valid_bytes=7, then 20 PAD words, one block, done.
REQ-032 msg_len=168, mode 0 -> 21 full-word handshakes, perm_start, then a second all-pad block, two perm_start total, then done.
REQ-033 msg_len=136, mode 1 (macro defined) -> 17 words, then second block; without the macro the same stimulus gives 21-word blocks.
REQ-034 msg_len=20 with din_valid low for 3 cycles after the first word -> idx and rem hold; words 2 and 3 carry remaining 0 (full) then 4; output matches the no-stall run.
REQ-035 rst=0 during PERMUTE -> all outputs 0 immediately; a new start after release runs a clean message with pad_reset pulsed.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE sizing constants and the absorb controller state type.
// Lane width is 64 bits; rates are expressed in 64-bit lanes per block.
package keccak_pkg;

   localparam int w             = 64;
   localparam int w_byte_size   = w / 8;
   localparam int w_byte_width  = $clog2(w_byte_size);
   localparam int LEN_W         = 32;
   localparam int RATE128_WORDS = 21;
   localparam int RATE256_WORDS = 17;

   typedef enum logic [1:0] {
      IDLE,
      ABSORB,
      PAD,
      PERMUTE
   } absorb_state_t;

endpackage

// File: rtl/absorb_controller.sv
// Feeds message lanes and padding lanes into the sponge one lane per cycle and
// hands full blocks to the permutation. Define ABSORB_CTRL_SHAKE256_EN to enable mode-selected rate.
module absorb_controller
   import keccak_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_W-1:0]        msg_len,
   input  logic                    mode,
   input  logic [w-1:0]            din,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic [w-1:0]            pad_data_in,
   output logic [w_byte_width-1:0] pad_remaining_valid_bytes,
   output logic                    pad_enable,
   output logic                    pad_last_word_in_block,
   output logic                    pad_reset,
   output logic                    absorb_valid,
   output logic [4:0]              absorb_idx,
   output logic                    perm_start,
   input  logic                    perm_done,
   output logic                    busy,
   output logic                    done
);

   absorb_state_t    state;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] rem_next;
   logic             pad_started;
   logic [4:0]       last_idx;
   logic             take;
   logic             in_pad;
   logic             short_word;

   function automatic logic [LEN_W-1:0] consume_word(input logic [LEN_W-1:0] r);
      return (r > LEN_W'(w_byte_size)) ? r - LEN_W'(w_byte_size) : '0;
   endfunction

`ifdef ABSORB_CTRL_SHAKE256_EN
   logic rate_256;
   assign last_idx = rate_256 ? 5'(RATE256_WORDS - 1) : 5'(RATE128_WORDS - 1);
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign last_idx    = 5'(RATE128_WORDS - 1);
`endif

   // A lane is absorbed either from the input stream or as a pure padding lane.
   assign take        = (state == ABSORB) && din_valid;
   assign in_pad      = (state == PAD);
   assign short_word  = take && (rem < LEN_W'(w_byte_size));
   assign rem_next    = consume_word(rem);

   assign din_ready                 = (state == ABSORB);
   assign absorb_valid              = take || in_pad;
   assign pad_data_in               = take ? din : '0;
   assign pad_enable                = short_word || in_pad;
   assign pad_remaining_valid_bytes = short_word ? rem[w_byte_width-1:0] : '0;
   assign pad_last_word_in_block    = absorb_valid && (absorb_idx == last_idx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         rem         <= '0;
         absorb_idx  <= '0;
         pad_started <= 1'b0;
         pad_reset   <= 1'b0;
         perm_start  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef ABSORB_CTRL_SHAKE256_EN
         rate_256    <= 1'b0;
`endif
      end else begin
         pad_reset  <= 1'b0;
         perm_start <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rem         <= msg_len;
                  absorb_idx  <= '0;
                  pad_started <= 1'b0;
                  pad_reset   <= 1'b1;
                  busy        <= 1'b1;
`ifdef ABSORB_CTRL_SHAKE256_EN
                  rate_256    <= mode;
`endif
                  state       <= (msg_len != '0) ? ABSORB : PAD;
               end
            end
            ABSORB: begin
               if (din_valid) begin
                  rem <= rem_next;
                  if (short_word) pad_started <= 1'b1;
                  if (pad_last_word_in_block) begin
                     absorb_idx <= '0;
                     perm_start <= 1'b1;
                     state      <= PERMUTE;
                  end else begin
                     absorb_idx <= absorb_idx + 5'd1;
                     if (rem_next == '0) state <= PAD;
                  end
               end
            end
            PAD: begin
               pad_started <= 1'b1;
               if (pad_last_word_in_block) begin
                  absorb_idx <= '0;
                  perm_start <= 1'b1;
                  state      <= PERMUTE;
               end else begin
                  absorb_idx <= absorb_idx + 5'd1;
               end
            end
            PERMUTE: begin
               // A message whose padding has begun ends with this permutation.
               if (perm_done) begin
                  if (pad_started) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (rem != '0) begin
                     state <= ABSORB;
                  end else begin
                     state <= PAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_absorb_controller.sv
// Randomized scoreboard bench for absorb_controller: a lane-level reference model
// queues the expected output events for each message and a monitor consumes them.
module tb_absorb_controller;
   import keccak_pkg::*;

   localparam int K_PRST = 0;
   localparam int K_ABS  = 1;
   localparam int K_PERM = 2;
   localparam int K_DONE = 3;

`ifdef ABSORB_CTRL_SHAKE256_EN
   localparam bit SHAKE256 = 1'b1;
`else
   localparam bit SHAKE256 = 1'b0;
`endif

   typedef struct {
      int          kind;
      logic [63:0] data;
      int          idx;
      logic        en;
      int          nb;
      logic        last;
   } ev_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [LEN_W-1:0]        msg_len;
   logic                    mode;
   logic [w-1:0]            din = '0;
   logic                    din_valid = 1'b0;
   logic                    din_ready;
   logic [w-1:0]            pad_data_in;
   logic [w_byte_width-1:0] pad_remaining_valid_bytes;
   logic                    pad_enable;
   logic                    pad_last_word_in_block;
   logic                    pad_reset;
   logic                    absorb_valid;
   logic [4:0]              absorb_idx;
   logic                    perm_start;
   logic                    perm_done = 1'b0;
   logic                    busy;
   logic                    done;

   ev_t         sb[$];
   logic [63:0] words[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          msg_seq  = 0;
   bit          hold_perm  = 1'b0;
   bit          stall_mode = 1'b0;

   absorb_controller dut (
      .clk                       (clk),
      .rst                       (rst),
      .start                     (start),
      .msg_len                   (msg_len),
      .mode                      (mode),
      .din                       (din),
      .din_valid                 (din_valid),
      .din_ready                 (din_ready),
      .pad_data_in               (pad_data_in),
      .pad_remaining_valid_bytes (pad_remaining_valid_bytes),
      .pad_enable                (pad_enable),
      .pad_last_word_in_block    (pad_last_word_in_block),
      .pad_reset                 (pad_reset),
      .absorb_valid              (absorb_valid),
      .absorb_idx                (absorb_idx),
      .perm_start                (perm_start),
      .perm_done                 (perm_done),
      .busy                      (busy),
      .done                      (done)
   );

   always #5 clk = ~clk;

   wire [79:0] outs = {din_ready, pad_data_in, pad_remaining_valid_bytes, pad_enable,
                       pad_last_word_in_block, pad_reset, absorb_valid, absorb_idx,
                       perm_start, busy, done};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_ev(input int kind, input string name, output ev_t e, output bit ok);
      n_checks++;
      ok = 1'b0;
      e  = '{kind: -1, data: '0, idx: 0, en: 1'b0, nb: 0, last: 1'b0};
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: output event %0d seen, none expected (t=%0t)", name, kind, $time);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind) begin
            n_fail++;
            $display("FAIL %s: got event %0d, expected event %0d (t=%0t)", name, kind, e.kind, $time);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   function automatic int rate_of(input logic m);
      return (m && SHAKE256) ? RATE256_WORDS : RATE128_WORDS;
   endfunction

   // Reference model: the message occupies whole lanes, padding fills the rest of
   // the block, and a message of an exact block multiple gets one more pad block.
   task automatic issue_msg(input int len, input logic m);
      ev_t e;
      int  r      = rate_of(m);
      int  blocks = len / (8 * r) + 1;
      int  nw     = (len + 7) / 8;
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back({$urandom, $urandom});
      sb.push_back('{kind: K_PRST, data: '0, idx: 0, en: 1'b0, nb: 0, last: 1'b0});
      for (int b = 0; b < blocks; b++) begin
         for (int i = 0; i < r; i++) begin
            int g = b * r + i;
            e.kind = K_ABS;
            e.idx  = i;
            e.last = (i == r - 1);
            if (8 * g < len) begin
               e.data = words[g];
               e.en   = (len - 8 * g) < 8;
               e.nb   = e.en ? len - 8 * g : 0;
            end else begin
               e.data = '0;
               e.en   = 1'b1;
               e.nb   = 0;
            end
            sb.push_back(e);
         end
         sb.push_back('{kind: K_PERM, data: '0, idx: 0, en: 1'b0, nb: 0, last: 1'b0});
      end
      sb.push_back('{kind: K_DONE, data: '0, idx: 0, en: 1'b0, nb: 0, last: 1'b0});
      msg_len = len;
      mode    = m;
      start   = 1'b1;
      msg_seq++;
      @(negedge clk); #3;
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
   endtask

   // Runs until every queued event is consumed, poking ignored starts while busy.
   task automatic wait_drain(input string name);
      for (int i = 0; i < 4000 && sb.size() != 0; i++) begin
         @(negedge clk); #3;
         if (sb.size() != 0) begin
            start   = busy && ($urandom_range(0, 3) == 0);
            msg_len = $urandom;
            mode    = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected events still pending after cycle budget", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_msg(input int len, input logic m);
      issue_msg(len, m);
      wait_drain($sformatf("drain_len%0d_mode%0d", len, m));
   endtask

   // Stimulus driver for the word stream and the permutation handshake.
   int ptr = 0, seen_seq = 0, stall_cnt = 0, pwait = 0;
   bit pending = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         pending   = 1'b0;
         perm_done = 1'b0;
         din_valid = 1'b0;
      end else begin
         if (msg_seq != seen_seq) begin
            seen_seq  = msg_seq;
            ptr       = 0;
            stall_cnt = 0;
         end
         if (stall_mode) begin
            if (ptr == 1 && stall_cnt < 3) begin
               din_valid = 1'b0;
               stall_cnt++;
            end else begin
               din_valid = 1'b1;
            end
         end else begin
            din_valid = ($urandom_range(0, 9) < 7);
         end
         din = (ptr < words.size()) ? words[ptr] : {$urandom, $urandom};
         if (din_ready && din_valid) ptr++;
         if (perm_start && !pending) begin
            pending = 1'b1;
            pwait   = $urandom_range(0, 3);
         end
         if (hold_perm) begin
            pending   = 1'b0;
            perm_done = 1'b0;
         end else if (pending) begin
            if (pwait == 0) begin
               perm_done = 1'b1;
               pending   = 1'b0;
            end else begin
               pwait--;
               perm_done = 1'b0;
            end
         end else begin
            perm_done = ($urandom_range(0, 5) == 0);
         end
      end
   end

   // Monitor: consumes expected events whenever the DUT presents one.
   always begin
      ev_t e;
      bit  ok;
      @(negedge clk); #2;
      if (rst) begin
         if (pad_reset) pop_ev(K_PRST, "pad_reset", e, ok);
         if (absorb_valid) begin
            pop_ev(K_ABS, "absorb_valid", e, ok);
            if (ok) begin
               check($sformatf("idx_lane%0d", e.idx), absorb_idx, e.idx);
               check($sformatf("data_lane%0d", e.idx), pad_data_in, e.data);
               check($sformatf("pad_en_lane%0d", e.idx), pad_enable, e.en);
               check($sformatf("pad_bytes_lane%0d", e.idx), pad_remaining_valid_bytes, e.nb);
               check($sformatf("last_lane%0d", e.idx), pad_last_word_in_block, e.last);
            end
         end
         if (perm_start) pop_ev(K_PERM, "perm_start", e, ok);
         if (done) pop_ev(K_DONE, "done", e, ok);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      msg_len = '0;
      mode    = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check("reset_outputs", outs, '0);
      rst = 1'b1;

      run_msg(0, 1'b0);
      run_msg(7, 1'b0);
      run_msg(168, 1'b0);
      run_msg(136, 1'b1);
      run_msg(136, 1'b0);
      stall_mode = 1'b1;
      run_msg(20, 1'b0);
      stall_mode = 1'b0;
      run_msg(20, 1'b0);
      run_msg(8, 1'b1);
      for (int i = 0; i < 25; i++)
         run_msg($urandom_range(0, 400), 1'($urandom_range(0, 1)));

      // Asynchronous reset while the permutation is outstanding.
      hold_perm = 1'b1;
      issue_msg(200, 1'b0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #3;
            seen = perm_start;
         end
         check("perm_start_before_reset", seen, 1'b1);
      end
      @(negedge clk); #3;
      rst = 1'b0;
      #1;
      check("outputs_at_reset_assert", outs, '0);
      sb.delete();
      hold_perm = 1'b0;
      @(negedge clk);
      @(negedge clk); #3;
      check("outputs_held_in_reset", outs, '0);
      rst = 1'b1;
      issue_msg(13, 1'b0);
      wait_drain("drain_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
